// File: rtl/program_counter_pkg.sv
// program_counter_pkg: shared opcodes, default vectors and action encoding for the fetch PC
package program_counter_pkg;
    localparam int ADDR_W = 32;
    localparam int STACK_DEPTH_DEF = 8;
    localparam logic [5:0] OP_JUMP = 6'b110011;
    localparam logic [5:0] OP_CALL = 6'b000011;
    localparam logic [5:0] OP_RET  = 6'b000110;
    localparam logic [ADDR_W-1:0] RESET_ADDR_DEF = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] I0_VEC_DEF     = 32'h0000_0100;
    localparam logic [ADDR_W-1:0] I1_VEC_DEF     = 32'h0000_0180;
    localparam logic [ADDR_W-1:0] TIMER_VEC_DEF  = 32'h0000_0200;
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_IRQ,
        ACT_RET,
        ACT_CALL,
        ACT_JUMP,
        ACT_SEQ
    } pc_action_e;
endpackage

// File: rtl/program_counter_return_stack.sv
// pc_return_stack: LIFO of {isr, addr} entries; push when full and pop when empty are ignored
module pc_return_stack #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W:0]   push_data_i,
    output logic [W:0]   top_data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] ONE = (PW+1)'(1);
    logic [W:0]    mem_q [DEPTH];
    logic [PW:0]   count_q, count_d;
    logic [PW-1:0] wr_idx, top_idx;
    logic          do_push, do_pop;
    assign full_o  = count_q == (PW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o & ~push_i;
    assign wr_idx  = count_q[PW-1:0];
    assign top_idx = wr_idx - PW'(1);
    assign top_data_o = mem_q[top_idx];
    // occupancy count moves by one per accepted push or pop
    always_comb begin
        count_d = do_push ? count_q + ONE : do_pop ? count_q - ONE : count_q;
    end
    // count register
    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end
    // entry storage; contents beyond count are don't-care so no reset is needed
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_idx] <= push_data_i;
    end
endmodule

// File: rtl/program_counter.sv
// program_counter: instruction-fetch PC with jump/call/return stack and three vectored interrupts
module program_counter
    import program_counter_pkg::*;
#(
    parameter int                ADDR_W      = program_counter_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = ADDR_W'(RESET_ADDR_DEF),
    parameter logic [ADDR_W-1:0] I0_VEC      = ADDR_W'(I0_VEC_DEF),
    parameter logic [ADDR_W-1:0] I1_VEC      = ADDR_W'(I1_VEC_DEF),
    parameter logic [ADDR_W-1:0] TIMER_VEC   = ADDR_W'(TIMER_VEC_DEF),
    parameter int                STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        control_signal,
    input  logic [ADDR_W-1:0] target_address,
    input  logic              fetch_complete,
    input  logic              is_function_return,
    input  logic              I0,
    input  logic              I1,
    input  logic              Timer_Interrupt,
    input  logic              start,
    output logic [ADDR_W-1:0] IM_ADDRESS_BUS
);
    logic [ADDR_W-1:0] pc_q, pc_d, pc_plus4, irq_vec;
    logic              running_q, running_d, in_isr_q, in_isr_d;
    logic              i0_q, i1_q, tmr_q;
    logic              i0_e, i1_e, tmr_e, irq_any;
    logic              push, pop, st_full, st_empty;
    logic [ADDR_W:0]   push_data, top_data;
    pc_action_e        act;
    assign i0_e     = I0 & ~i0_q;
    assign i1_e     = I1 & ~i1_q;
    assign tmr_e    = Timer_Interrupt & ~tmr_q;
    assign irq_any  = i0_e | i1_e | tmr_e;
    assign irq_vec  = i0_e ? I0_VEC : tmr_e ? TIMER_VEC : I1_VEC;
    assign pc_plus4 = pc_q + ADDR_W'(4);
    assign IM_ADDRESS_BUS = pc_q;
    // pick the single highest-priority action for this edge; nothing acts while idle
    always_comb begin
        act = ACT_NONE;
        if (running_q)
            act = (irq_any && !in_isr_q)                              ? ACT_IRQ  :
                  (control_signal == OP_RET && is_function_return)   ? ACT_RET  :
                  (control_signal == OP_CALL)                        ? ACT_CALL :
                  (control_signal == OP_JUMP)                        ? ACT_JUMP :
                  fetch_complete                                     ? ACT_SEQ  : ACT_NONE;
    end
    // next PC, flags and stack requests for the chosen action
    always_comb begin
        pc_d      = pc_q;
        running_d = running_q | start;
        in_isr_d  = in_isr_q;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = '0;
        case (act)
            ACT_IRQ: begin
                push      = 1'b1;
                push_data = {1'b1, pc_q};
                pc_d      = irq_vec;
                in_isr_d  = 1'b1;
            end
            ACT_RET: begin
                pop      = ~st_empty;
                pc_d     = st_empty ? pc_q : top_data[ADDR_W-1:0];
                in_isr_d = in_isr_q & ~(~st_empty & top_data[ADDR_W]);
            end
            ACT_CALL: begin
                push      = 1'b1;
                push_data = {1'b0, pc_plus4};
                pc_d      = target_address;
            end
            ACT_JUMP: pc_d = target_address;
            ACT_SEQ:  pc_d = pc_plus4;
            default:  pc_d = pc_q;
        endcase
    end
    // PC and control flags
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_ADDR;
            running_q <= 1'b0;
            in_isr_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            running_q <= running_d;
            in_isr_q  <= in_isr_d;
        end
    end
    // interrupt edge detectors track inputs every cycle, idle included
    always_ff @(posedge clk) begin
        if (reset) begin
            i0_q  <= 1'b0;
            i1_q  <= 1'b0;
            tmr_q <= 1'b0;
        end else begin
            i0_q  <= I0;
            i1_q  <= I1;
            tmr_q <= Timer_Interrupt;
        end
    end
    pc_return_stack #(
        .W     (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (push_data),
        .top_data_o  (top_data),
        .full_o      (st_full),
        .empty_o     (st_empty)
    );
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed scoreboard bench for program_counter
module tb_program_counter;
    localparam logic [5:0] JMP = 6'b110011;
    localparam logic [5:0] CAL = 6'b000011;
    localparam logic [5:0] RTN = 6'b000110;
    typedef struct {
        logic [31:0] addr;
        string       nm;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  control_signal = '0;
    logic [31:0] target_address = '0;
    logic        fetch_complete = 1'b0;
    logic        is_function_return = 1'b0;
    logic        I0 = 1'b0;
    logic        I1 = 1'b0;
    logic        Timer_Interrupt = 1'b0;
    logic        start = 1'b0;
    logic [31:0] IM_ADDRESS_BUS;
    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    program_counter dut (
        .clk                (clk),
        .reset              (reset),
        .control_signal     (control_signal),
        .target_address     (target_address),
        .fetch_complete     (fetch_complete),
        .is_function_return (is_function_return),
        .I0                 (I0),
        .I1                 (I1),
        .Timer_Interrupt    (Timer_Interrupt),
        .start              (start),
        .IM_ADDRESS_BUS     (IM_ADDRESS_BUS)
    );
    always #5 clk = ~clk;
    // irq = {I0, Timer_Interrupt, I1}; every input is a one-cycle pulse
    task automatic step(input logic [5:0] c, input logic [31:0] t, input logic f, input logic q,
                        input logic [2:0] irq, input logic s, input logic [31:0] exp, input string nm);
        control_signal     = c;
        target_address     = t;
        fetch_complete     = f;
        is_function_return = q;
        {I0, Timer_Interrupt, I1} = irq;
        start              = s;
        @(posedge clk);
        sb.push_back('{exp, nm});
        #1;
        control_signal     = '0;
        target_address     = '0;
        fetch_complete     = 1'b0;
        is_function_return = 1'b0;
        {I0, Timer_Interrupt, I1} = 3'b000;
        start              = 1'b0;
    endtask
    // monitor: the bus is a registered output, checked mid-cycle after each edge
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                n_cmp++;
                if (IM_ADDRESS_BUS !== e.addr) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", e.nm, IM_ADDRESS_BUS, e.addr);
                end
            end
        end
    end
    initial begin
        reset = 1'b1;
        step(0, 0, 1, 0, 3'b000, 0, 32'h0, "reset0");
        step(0, 0, 0, 0, 3'b000, 1, 32'h0, "reset1");
        reset = 1'b0;
        step(0,   0,     1, 0, 3'b000, 0, 32'h0, "idle_fetch");
        step(JMP, 32'h40, 0, 0, 3'b000, 0, 32'h0, "idle_jump");
        step(0,   0,     0, 0, 3'b100, 0, 32'h0, "idle_irq");
        step(0,   0,     0, 0, 3'b000, 1, 32'h0, "start");
        for (int k = 1; k <= 4; k++)
            step(0, 0, 1, 0, 3'b000, 0, 32'(4 * k), $sformatf("seq%0d", k));
        step(JMP, 32'hA0, 0, 0, 3'b000, 0, 32'hA0, "jump");
        step(0,   0,      1, 0, 3'b000, 0, 32'hA4, "jump_seq");
        step(CAL, 32'hC0, 0, 0, 3'b000, 0, 32'hC0, "call");
        step(RTN, 0,      0, 1, 3'b000, 0, 32'hA8, "ret");
        step(RTN, 0,      0, 0, 3'b000, 0, 32'hA8, "ret_unqual");
        step(0,   0,      0, 0, 3'b100, 0, 32'h100, "irq_i0");
        step(0,   0,      0, 0, 3'b000, 0, 32'h100, "isr_hold");
        step(0,   0,      0, 0, 3'b101, 0, 32'h100, "isr_drop");
        step(RTN, 0,      0, 1, 3'b000, 0, 32'hA8, "isr_ret");
        step(JMP, 32'h300, 1, 0, 3'b001, 0, 32'h180, "irq_i1_prio");
        step(RTN, 0,      0, 1, 3'b000, 0, 32'hA8, "ret_i1");
        step(0,   0,      0, 0, 3'b110, 0, 32'h100, "irq_i0_tmr");
        step(RTN, 0,      0, 1, 3'b000, 0, 32'hA8, "ret_i0");
        step(0,   0,      0, 0, 3'b011, 0, 32'h200, "irq_tmr_i1");
        step(RTN, 0,      0, 1, 3'b000, 0, 32'hA8, "ret_tmr");
        step(JMP, 32'hFFFF_FFFC, 0, 0, 3'b000, 0, 32'hFFFF_FFFC, "jump_top");
        step(0,   0,      1, 0, 3'b000, 0, 32'h0, "wrap");
        step(JMP, 32'h1000, 0, 0, 3'b000, 0, 32'h1000, "jump_base");
        for (int k = 0; k < 9; k++)
            step(CAL, 32'h2000 + 32'(16 * k), 0, 0, 3'b000, 0, 32'h2000 + 32'(16 * k), $sformatf("ncall%0d", k));
        for (int k = 7; k >= 0; k--)
            step(RTN, 0, 0, 1, 3'b000, 0, (k == 0) ? 32'h1004 : 32'h2004 + 32'(16 * (k - 1)), $sformatf("nret%0d", k));
        step(RTN, 0, 0, 1, 3'b000, 0, 32'h1004, "ret_empty");
        reset = 1'b1;
        step(0, 0, 1, 0, 3'b000, 0, 32'h0, "reset_run");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
